// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master between N register clients.
// Grants one request at a time, strobes the master, and reports DONE/ERR/RDATA.
module spi_master_arbiter #(
  parameter int D        = 8,
  parameter int A        = 4,
  parameter int N        = 4,
  parameter int START_TO = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_wr,
  input  logic [N*A-1:0] req_addr,
  input  logic [N*D-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           err,
  output logic [D-1:0]   rdata,
  output logic           m_wr,
  output logic           m_rd,
  output logic [A-1:0]   m_addr,
  output logic [D-1:0]   m_datai,
  input  logic [D-1:0]   m_datao,
  input  logic           m_busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(START_TO + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] sel, sel_nxt;
  logic [PW-1:0] pick, sel_inc;
  logic          found;
  logic          op, op_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  gnt_nxt, done_nxt, sel_oh;
  logic          err_nxt, m_wr_nxt, m_rd_nxt;
  logic [D-1:0]  rdata_nxt, m_datai_nxt;
  logic [A-1:0]  m_addr_nxt;

  // first requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + i) % N);
      end
    end
  end

  assign sel_oh  = N'(1) << sel;
  assign sel_inc = (int'(sel) == N - 1) ? '0 : sel + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      op      <= 1'b0;
      cnt     <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      m_wr    <= 1'b0;
      m_rd    <= 1'b0;
      m_addr  <= '0;
      m_datai <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      sel     <= sel_nxt;
      op      <= op_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      rdata   <= rdata_nxt;
      m_wr    <= m_wr_nxt;
      m_rd    <= m_rd_nxt;
      m_addr  <= m_addr_nxt;
      m_datai <= m_datai_nxt;
    end
  end

  // next values are registered, so each output shows up in the named state
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    op_nxt      = op;
    cnt_nxt     = cnt;
    gnt_nxt     = '0;
    done_nxt    = '0;
    err_nxt     = 1'b0;
    rdata_nxt   = rdata;
    m_wr_nxt    = 1'b0;
    m_rd_nxt    = 1'b0;
    m_addr_nxt  = m_addr;
    m_datai_nxt = m_datai;
    unique case (state)
      IDLE: begin
        if (found && !m_busy) begin
          sel_nxt     = pick;
          op_nxt      = req_wr[pick];
          m_addr_nxt  = req_addr[int'(pick)*A +: A];
          m_datai_nxt = req_data[int'(pick)*D +: D];
          gnt_nxt     = N'(1) << pick;
          m_wr_nxt    = req_wr[pick];
          m_rd_nxt    = ~req_wr[pick];
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (m_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(START_TO - 1)) begin
          done_nxt  = sel_oh;
          err_nxt   = 1'b1;
          ptr_nxt   = sel_inc;
          state_nxt = COMPLETE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!m_busy) begin
          done_nxt  = sel_oh;
          ptr_nxt   = sel_inc;
          state_nxt = COMPLETE;
          if (!op) rdata_nxt = m_datao;
        end
      end
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

endmodule
